// File: rtl/inst_memory_pipe.sv
// Pipelined word memory: valid/ready request port, one-cycle registered response.
// Define INST_MEM_ZERO_FILL_EN to zero-fill every word after reset (busy during fill).
module inst_memory_pipe #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic                req_we,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_err,
    output logic                busy
);

    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BE_W - 1);

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_err;

    logic [ADDR_W-1:0] w_idx_full;
    logic [IDX_W-1:0]  w_idx;
    logic              w_mis;
    logic              w_oor;
    logic              w_err;
    logic              w_acc;
    logic              w_wr;
    logic              w_run;
    logic              w_fill_we;
    logic [IDX_W-1:0]  w_fill_idx;

    assign w_idx_full = req_addr >> OFF_W;
    assign w_idx      = w_idx_full[IDX_W-1:0];
    assign w_mis      = |(req_addr & OFF_MASK);
    assign w_oor      = (w_idx_full >= ADDR_W'(DEPTH));
    assign w_err      = w_mis | w_oor;

`ifdef INST_MEM_ZERO_FILL_EN
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [IDX_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_INIT)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        if (r_state == ST_INIT && r_cnt == IDX_W'(DEPTH - 1))
            w_next = ST_RUN;
    end

    assign w_run      = (r_state == ST_RUN);
    assign busy       = (r_state == ST_INIT);
    assign w_fill_we  = (r_state == ST_INIT) && !reset;
    assign w_fill_idx = r_cnt;
`else
    assign w_run      = 1'b1;
    assign busy       = 1'b0;
    assign w_fill_we  = 1'b0;
    assign w_fill_idx = '0;
`endif

    // Ready drops combinationally with reset so nothing is accepted at a reset edge.
    assign req_ready = w_run && !reset;
    assign w_acc     = req_valid && req_ready;
    assign w_wr      = w_acc && req_we && !w_err;

    always_ff @(posedge clk) begin
        if (w_fill_we) begin
            r_mem[w_fill_idx] <= '0;
        end else if (w_wr) begin
            for (int k = 0; k < BE_W; k++) begin
                if (req_be[k])
                    r_mem[w_idx][k*8 +: 8] <= req_wdata[k*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= w_acc;
            if (w_acc) begin
                r_err  <= w_err;
                r_data <= (w_err || req_we) ? '0 : r_mem[w_idx];
            end
        end
    end

    assign rsp_valid = r_valid;
    assign rsp_data  = r_data;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_inst_memory_pipe.sv
// Directed self-checking bench for inst_memory_pipe (DATA_W=32, DEPTH=64).
// Covers the zero-fill sequence too when INST_MEM_ZERO_FILL_EN is defined.
module tb_inst_memory_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;

    int n_tot = 0;
    int n_bad = 0;

    inst_memory_pipe #(.DATA_W(32), .DEPTH(64), .ADDR_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] be);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic rsp_chk(input string tag, input logic [31:0] d, input logic e);
        chk({tag, "_v"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, "_d"}, rsp_data, d);
        chk({tag, "_e"}, {31'd0, rsp_err}, {31'd0, e});
    endtask

    task automatic fill_wait(input string tag);
        int n;
        n = 0;
        while (busy && n < 200) begin
            if (req_ready) chk({tag, "_rdy_busy"}, {31'd0, req_ready}, 32'd0);
            n++;
            @(posedge clk);
            #1;
        end
        chk({tag, "_len"}, n, 32'd64);
        chk({tag, "_rdy"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_data", rsp_data, 32'd0);
        chk("rst_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        reset = 1'b0;
`ifdef INST_MEM_ZERO_FILL_EN
        chk("init_busy", {31'd0, busy}, 32'd1);
        fill_wait("fill0");
`else
        #1;
        chk("run_busy", {31'd0, busy}, 32'd0);
        chk("run_ready", {31'd0, req_ready}, 32'd1);
`endif

        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        rsp_chk("wr10", 32'h0, 1'b0);
        do_req(1'b0, 32'h10, 32'h0, 4'h0);
        rsp_chk("rd10", 32'hDEADBEEF, 1'b0);
        idle();
        chk("idle_v", {31'd0, rsp_valid}, 32'd0);
        chk("idle_hold", rsp_data, 32'hDEADBEEF);

        do_req(1'b1, 32'h10, 32'h000000AA, 4'b0001);
        rsp_chk("wrbe", 32'h0, 1'b0);
        do_req(1'b0, 32'h10, 32'h0, 4'h0);
        rsp_chk("rdbe", 32'hDEADBEAA, 1'b0);

        do_req(1'b1, 32'hFC, 32'h12345678, 4'hF);
        rsp_chk("wrFC", 32'h0, 1'b0);
        do_req(1'b0, 32'h12, 32'h0, 4'h0);
        rsp_chk("mis", 32'h0, 1'b1);
        do_req(1'b0, 32'h100, 32'h0, 4'h0);
        rsp_chk("oor", 32'h0, 1'b1);
        do_req(1'b0, 32'hFC, 32'h0, 4'h0);
        rsp_chk("rdFC", 32'h12345678, 1'b0);

        do_req(1'b1, 32'h11, 32'hFFFFFFFF, 4'hF);
        rsp_chk("wrmis", 32'h0, 1'b1);
        do_req(1'b1, 32'h200, 32'h55555555, 4'hF);
        rsp_chk("wroor", 32'h0, 1'b1);
        do_req(1'b0, 32'h10, 32'h0, 4'h0);
        rsp_chk("nowr", 32'hDEADBEAA, 1'b0);

        do_req(1'b1, 32'h0, 32'h11111111, 4'hF);
        do_req(1'b1, 32'h4, 32'h22222222, 4'hF);
        do_req(1'b1, 32'h8, 32'h33333333, 4'hF);
        do_req(1'b0, 32'h0, 32'h0, 4'h0);
        rsp_chk("b2b0", 32'h11111111, 1'b0);
        chk("b2b0_rdy", {31'd0, req_ready}, 32'd1);
        do_req(1'b0, 32'h4, 32'h0, 4'h0);
        rsp_chk("b2b1", 32'h22222222, 1'b0);
        chk("b2b1_rdy", {31'd0, req_ready}, 32'd1);
        do_req(1'b0, 32'h8, 32'h0, 4'h0);
        rsp_chk("b2b2", 32'h33333333, 1'b0);
        idle();
        chk("b2b_end", {31'd0, rsp_valid}, 32'd0);

        do_req(1'b0, 32'h10, 32'h0, 4'h0);
        rsp_chk("prerst", 32'hDEADBEAA, 1'b0);
        req_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_v", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_d", rsp_data, 32'd0);
        @(posedge clk);
        #1;
        chk("midrst_v2", {31'd0, rsp_valid}, 32'd0);
        reset = 1'b0;

`ifdef INST_MEM_ZERO_FILL_EN
        fill_wait("fill1");
        for (int i = 0; i < 64; i++)
            do_req(1'b1, 32'(i * 4), 32'hA5A50000 | 32'(i + 1), 4'hF);
        do_req(1'b0, 32'h14, 32'h0, 4'h0);
        rsp_chk("prefill", 32'hA5A50006, 1'b0);
        req_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("fill30_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        fill_wait("fill2");
        for (int i = 0; i < 64; i++) begin
            do_req(1'b0, 32'(i * 4), 32'h0, 4'h0);
            chk("zero_d", rsp_data, 32'h0);
        end
        idle();
`endif

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
